// File: rtl/ide_mgmt_arb.sv
// Two-channel IDE management arbiter: round-robin grant of the shared management
// port, host access routing, and a grant-idle watchdog.
module ide_mgmt_arb #(
    parameter int TMO_W = 20
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [2:0]  ch0_request,
    input  logic [2:0]  ch1_request,
    output logic [3:0]  mgmt_address,
    output logic [15:0] mgmt_writedata,
    output logic        ch0_mgmt_write,
    output logic        ch0_mgmt_read,
    output logic        ch1_mgmt_write,
    output logic        ch1_mgmt_read,
    input  logic [15:0] ch0_mgmt_readdata,
    input  logic [15:0] ch1_mgmt_readdata,
    input  logic [3:0]  h_address,
    input  logic        h_write,
    input  logic        h_read,
    input  logic [15:0] h_writedata,
    output logic [15:0] h_readdata,
    input  logic        cfg_sel,
    output logic        grant_valid,
    output logic        grant_ch,
    output logic [2:0]  grant_req,
    output logic        host_irq,
    output logic        tmo_flag,
    input  logic        tmo_clr
);

    typedef enum logic [1:0] {S_IDLE, S_GRANT, S_RELEASE} state_t;

    state_t           r_state, w_next;
    logic             r_grant_ch, r_last_ch, r_rel_cnt, r_strb_q, r_tmo_flag;
    logic [2:0]       r_grant_req;
    logic [TMO_W-1:0] r_wdog;
    logic [15:0]      r_h_readdata;

    logic [1:0]  w_pend;
    logic        w_pick, w_rel_host, w_tmo, w_hold, w_tgt, w_strb, w_tmo_set;
    logic [2:0]  w_pick_req, w_gnt_live;

    assign w_pend     = {|ch1_request, |ch0_request};
    // Tie goes to the channel that did not win last time.
    assign w_pick     = (w_pend == 2'b11) ? ~r_last_ch : w_pend[1];
    assign w_pick_req = w_pick ? ch1_request : ch0_request;
    assign w_gnt_live = r_grant_ch ? ch1_request : ch0_request;
    assign w_strb     = h_write | h_read;
    assign w_rel_host = h_write && (h_address == 4'd5);
    assign w_tmo      = &r_wdog;
    // A strobe held from the last GRANT cycle stays on the old channel for one cycle.
    assign w_hold     = (r_state == S_RELEASE) && !r_rel_cnt && r_strb_q && w_strb;
    assign w_tgt      = ((r_state == S_GRANT) || w_hold) ? r_grant_ch : cfg_sel;
    assign w_tmo_set  = (r_state == S_GRANT) && w_tmo && !w_rel_host;

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:    if (|w_pend) w_next = S_GRANT;
            S_GRANT:   if (w_rel_host || (w_gnt_live == 3'b000) || w_tmo) w_next = S_RELEASE;
            S_RELEASE: if (r_rel_cnt) w_next = S_IDLE;
            default:   w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= S_IDLE;
            r_grant_ch   <= 1'b0;
            r_grant_req  <= 3'b000;
            r_last_ch    <= 1'b1;
            r_rel_cnt    <= 1'b0;
            r_strb_q     <= 1'b0;
            r_tmo_flag   <= 1'b0;
            r_wdog       <= '0;
            r_h_readdata <= 16'h0000;
        end else begin
            r_state  <= w_next;
            r_strb_q <= w_strb;
            if ((r_state == S_IDLE) && (|w_pend)) begin
                r_grant_ch  <= w_pick;
                r_grant_req <= w_pick_req;
                r_last_ch   <= w_pick;
            end
            if ((r_state != S_GRANT) || w_strb)
                r_wdog <= '0;
            else
                r_wdog <= r_wdog + TMO_W'(1);
            r_rel_cnt <= (r_state == S_RELEASE) ? ~r_rel_cnt : 1'b0;
            if (w_tmo_set)
                r_tmo_flag <= 1'b1;
            else if (tmo_clr)
                r_tmo_flag <= 1'b0;
            r_h_readdata <= w_tgt ? ch1_mgmt_readdata : ch0_mgmt_readdata;
        end
    end

    assign mgmt_address   = h_address;
    assign mgmt_writedata = h_writedata;
    assign ch0_mgmt_write = h_write & ~w_tgt;
    assign ch0_mgmt_read  = h_read  & ~w_tgt;
    assign ch1_mgmt_write = h_write &  w_tgt;
    assign ch1_mgmt_read  = h_read  &  w_tgt;
    assign h_readdata     = r_h_readdata;
    assign grant_valid    = (r_state == S_GRANT);
    assign host_irq       = (r_state == S_GRANT);
    assign grant_ch       = r_grant_ch;
    assign grant_req      = r_grant_req;
    assign tmo_flag       = r_tmo_flag;

endmodule

// File: tb/tb_ide_mgmt_arb.sv
// Directed bench for ide_mgmt_arb with a 4-bit watchdog.
module tb_ide_mgmt_arb;
    logic        clk = 1'b0;
    logic        rst_n;
    logic [2:0]  ch0_request, ch1_request;
    logic [3:0]  mgmt_address;
    logic [15:0] mgmt_writedata;
    logic        ch0_mgmt_write, ch0_mgmt_read, ch1_mgmt_write, ch1_mgmt_read;
    logic [15:0] ch0_mgmt_readdata, ch1_mgmt_readdata;
    logic [3:0]  h_address;
    logic        h_write, h_read;
    logic [15:0] h_writedata, h_readdata;
    logic        cfg_sel, grant_valid, grant_ch, host_irq, tmo_flag, tmo_clr;
    logic [2:0]  grant_req;

    int total = 0;
    int bad   = 0;

    ide_mgmt_arb #(.TMO_W(4)) dut (
        .clk(clk), .rst_n(rst_n),
        .ch0_request(ch0_request), .ch1_request(ch1_request),
        .mgmt_address(mgmt_address), .mgmt_writedata(mgmt_writedata),
        .ch0_mgmt_write(ch0_mgmt_write), .ch0_mgmt_read(ch0_mgmt_read),
        .ch1_mgmt_write(ch1_mgmt_write), .ch1_mgmt_read(ch1_mgmt_read),
        .ch0_mgmt_readdata(ch0_mgmt_readdata), .ch1_mgmt_readdata(ch1_mgmt_readdata),
        .h_address(h_address), .h_write(h_write), .h_read(h_read),
        .h_writedata(h_writedata), .h_readdata(h_readdata),
        .cfg_sel(cfg_sel), .grant_valid(grant_valid), .grant_ch(grant_ch),
        .grant_req(grant_req), .host_irq(host_irq),
        .tmo_flag(tmo_flag), .tmo_clr(tmo_clr)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        rst_n = 1'b0; ch0_request = 3'b000; ch1_request = 3'b000;
        ch0_mgmt_readdata = 16'h1234; ch1_mgmt_readdata = 16'hBEEF;
        h_address = 4'd0; h_write = 1'b0; h_read = 1'b0; h_writedata = 16'h0000;
        cfg_sel = 1'b0; tmo_clr = 1'b0;
        step(); step();
        chk("rst_gv", grant_valid, 0);
        chk("rst_gch", grant_ch, 0);
        chk("rst_greq", grant_req, 0);
        chk("rst_irq", host_irq, 0);
        chk("rst_tmo", tmo_flag, 0);
        chk("rst_hrd", h_readdata, 0);
        rst_n = 1'b1;
        step();

        // Tie from reset: ch0 first, then ch1 after host release.
        ch0_request = 3'b101; ch1_request = 3'b101;
        step();
        chk("tie_gv", grant_valid, 1);
        chk("tie_gch", grant_ch, 0);
        chk("tie_greq", grant_req, 3'b101);
        h_write = 1'b1; h_address = 4'd5;
        #1;
        chk("rel_wr_ch0", ch0_mgmt_write, 1);
        chk("rel_wr_ch1", ch1_mgmt_write, 0);
        step();
        h_write = 1'b0;
        chk("rel1_gv", grant_valid, 0);
        step();
        chk("rel2_gv", grant_valid, 0);
        step();
        chk("idle_gv", grant_valid, 0);
        step();
        chk("rr_gv", grant_valid, 1);
        chk("rr_gch", grant_ch, 1);

        // Host read routed to granted ch1.
        h_read = 1'b1; h_address = 4'd1;
        #1;
        chk("rd_ch1", ch1_mgmt_read, 1);
        chk("rd_ch0", ch0_mgmt_read, 0);
        chk("rd_addr", mgmt_address, 4'd1);
        step();
        h_read = 1'b0;
        chk("rd_data", h_readdata, 16'hBEEF);

        // Release strobe held across the GRANT->RELEASE edge.
        h_write = 1'b1; h_address = 4'd5; cfg_sel = 1'b0;
        step();
        chk("hold_gv", grant_valid, 0);
        chk("hold_ch1", ch1_mgmt_write, 1);
        chk("hold_ch0", ch0_mgmt_write, 0);
        ch0_request = 3'b000; ch1_request = 3'b000;
        step();
        chk("post_ch0", ch0_mgmt_write, 1);
        chk("post_ch1", ch1_mgmt_write, 0);
        h_write = 1'b0;
        step();

        // Configuration write while idle.
        cfg_sel = 1'b1; h_write = 1'b1; h_address = 4'd6; h_writedata = 16'h0303;
        #1;
        chk("cfg_ch1", ch1_mgmt_write, 1);
        chk("cfg_ch0", ch0_mgmt_write, 0);
        chk("cfg_data", mgmt_writedata, 16'h0303);
        chk("cfg_addr", mgmt_address, 4'd6);
        step();
        h_write = 1'b0;
        chk("cfg_gv", grant_valid, 0);

        // Single request, grant_req stays latched, drop ends grant.
        ch0_request = 3'b100;
        step();
        chk("one_gv", grant_valid, 1);
        chk("one_gch", grant_ch, 0);
        chk("one_greq", grant_req, 3'b100);
        chk("one_irq", host_irq, 1);
        ch0_request = 3'b010;
        step();
        chk("latch_greq", grant_req, 3'b100);
        ch0_request = 3'b000;
        step();
        chk("drop_gv", grant_valid, 0);
        step(); step();

        // Watchdog expiry.
        ch0_request = 3'b001;
        step();
        chk("wd_gv0", grant_valid, 1);
        repeat (15) step();
        chk("wd_gv15", grant_valid, 1);
        chk("wd_tmo15", tmo_flag, 0);
        step();
        chk("wd_gv16", grant_valid, 0);
        chk("wd_tmo16", tmo_flag, 1);
        ch0_request = 3'b000; tmo_clr = 1'b1;
        step();
        tmo_clr = 1'b0;
        chk("wd_clr", tmo_flag, 0);
        step(); step();

        // Set and clear in the same cycle: set wins.
        ch0_request = 3'b001;
        step();
        repeat (15) step();
        tmo_clr = 1'b1;
        step();
        tmo_clr = 1'b0;
        chk("setclr_tmo", tmo_flag, 1);
        chk("setclr_gv", grant_valid, 0);
        ch0_request = 3'b000; tmo_clr = 1'b1;
        step();
        tmo_clr = 1'b0;
        chk("setclr_clr", tmo_flag, 0);
        step(); step();

        // Host release coincident with expiry: no flag.
        ch0_request = 3'b001;
        step();
        repeat (15) step();
        h_write = 1'b1; h_address = 4'd5;
        step();
        h_write = 1'b0;
        chk("race_gv", grant_valid, 0);
        chk("race_tmo", tmo_flag, 0);
        ch0_request = 3'b000;
        step(); step(); step();

        // Reset mid-grant, then regrant of the still-pending channel.
        ch1_request = 3'b100;
        step();
        chk("mid_gch", grant_ch, 1);
        step();
        chk("mid_hrd", h_readdata, 16'hBEEF);
        #2 rst_n = 1'b0;
        #1;
        chk("mr_gv", grant_valid, 0);
        chk("mr_irq", host_irq, 0);
        chk("mr_gch", grant_ch, 0);
        chk("mr_greq", grant_req, 0);
        chk("mr_hrd", h_readdata, 0);
        step();
        rst_n = 1'b1;
        step();
        chk("mr_regv", grant_valid, 1);
        chk("mr_regch", grant_ch, 1);
        chk("mr_regreq", grant_req, 3'b100);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
